// File: rtl/cla_pkg.sv
// cla_pkg: shared widths and types for the carry-lookahead adder
package cla_pkg;
   localparam int WIDTH = 32;
   localparam int BLK = 4;
   localparam int NBLK = WIDTH / BLK;
   typedef logic [WIDTH-1:0] word_t;
   // Mask with bits lo..hi set; empty (all zero) when lo > hi.
   function automatic logic [NBLK-1:0] span(input int lo, input int hi);
      return NBLK'(((NBLK + 1)'(1) << (hi + 1)) - ((NBLK + 1)'(1) << lo));
   endfunction
endpackage

// File: rtl/cla_block4.sv
// cla_block4: 4-bit lookahead block producing sum bits and group propagate/generate
module cla_block4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       P,
   output logic       G
);
   logic [3:0] g, p, c;
   assign g = a & b;
   assign p = a ^ b;
   // Every internal carry is a flat sum of products of the block carry-in.
   assign c[0] = cin;
   assign c[1] = g[0] | p[0] & cin;
   assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & cin;
   assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cin;
   assign s = p ^ c;
   // Group signals depend only on the operands, never on cin.
   assign P = &p;
   assign G = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
endmodule

// File: rtl/cla_adder.sv
// cla_adder: registered 32-bit two-level carry-lookahead adder; optional ovf output with CLA_OVF_EN
module cla_adder
   import cla_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef CLA_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] S,
   output logic             Cout
);
   logic [NBLK-1:0] bp, bg;
   logic [NBLK:0] bc;
   word_t sum;
   assign bc[0] = Cin;
   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      cla_block4 u_blk (
         .a(A[BLK*k +: BLK]),
         .b(B[BLK*k +: BLK]),
         .cin(bc[k]),
         .s(sum[BLK*k +: BLK]),
         .P(bp[k]),
         .G(bg[k])
      );
   end
   // Block carry k+1 as a flat OR of product terms: each G[j] masked by P[j+1..k], plus Cin masked by P[0..k].
   for (genvar k = 0; k < NBLK; k++) begin : g_la
      logic [k+1:0] t;
      assign t[k+1] = Cin & (&(bp | ~span(0, k)));
      for (genvar j = 0; j <= k; j++) begin : g_t
         assign t[j] = bg[j] & (&(bp | ~span(j + 1, k)));
      end
      assign bc[k+1] = |t;
   end
`ifdef CLA_OVF_EN
   logic c31;
   // Carry into bit 31 recovered from its sum bit, avoiding an extra block output.
   assign c31 = sum[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1];
`endif
   // Capture the result every edge; reset wins over capture.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         S <= '0;
         Cout <= 1'b0;
`ifdef CLA_OVF_EN
         ovf <= 1'b0;
`endif
      end else begin
         S <= sum;
         Cout <= bc[NBLK];
`ifdef CLA_OVF_EN
         ovf <= bc[NBLK] ^ c31;
`endif
      end
   end
endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: directed and random checks of cla_adder against an arithmetic model
module tb_cla_adder;
   logic clock = 1'b0;
   logic reset_n;
   logic [31:0] A, B, S;
   logic Cin, Cout, ovf;
   logic [32:0] exp_sum;
   logic exp_ovf;
   logic valid = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   cla_adder dut (
      .clock(clock),
      .reset_n(reset_n),
      .A(A),
      .B(B),
      .Cin(Cin),
`ifdef CLA_OVF_EN
      .ovf(ovf),
`endif
      .S(S),
      .Cout(Cout)
   );
`ifndef CLA_OVF_EN
   assign ovf = 1'b0;
`endif

   // Model: plain 33-bit sum and signed-range test of the sampled operands.
   always @(posedge clock) begin
      longint sv;
      sv = longint'($signed(A)) + longint'($signed(B)) + longint'(Cin);
      exp_sum <= reset_n ? {1'b0, A} + {1'b0, B} + {32'd0, Cin} : 33'd0;
      exp_ovf <= reset_n && (sv > 64'sd2147483647 || sv < -64'sd2147483648);
      valid <= 1'b1;
   end

   // Compare DUT against the model on every falling edge once outputs are defined.
   always @(negedge clock) begin
      if (valid) begin
         checks++;
         if ({Cout, S} !== exp_sum) begin
            errors++;
            $display("FAIL model_sum: got %h/%0b expected %h/%0b", S, Cout, exp_sum[31:0], exp_sum[32]);
         end
`ifdef CLA_OVF_EN
         checks++;
         if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL model_ovf: got %0b expected %0b", ovf, exp_ovf);
         end
`endif
      end
   end

   task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b, input logic c);
      reset_n = r;
      A = a;
      B = b;
      Cin = c;
      @(posedge clock);
      #1;
   endtask

   task automatic lit(input string name, input logic [31:0] es, input logic ec, input logic eo);
      checks++;
      if (S !== es || Cout !== ec) begin
         errors++;
         $display("FAIL %s: got S=%h Cout=%0b expected S=%h Cout=%0b", name, S, Cout, es, ec);
      end
`ifdef CLA_OVF_EN
      checks++;
      if (ovf !== eo) begin
         errors++;
         $display("FAIL %s_ovf: got %0b expected %0b", name, ovf, eo);
      end
`else
      if (eo) begin end
`endif
   endtask

   initial begin
      step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      lit("reset1", 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      lit("reset2", 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      lit("first_after_reset", 32'hFFFFFFFF, 1'b1, 1'b0);
      step(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      lit("full_chain", 32'h00000000, 1'b1, 1'b0);
      step(1'b1, 32'h0000000F, 32'h00000001, 1'b0);
      lit("block_boundary", 32'h00000010, 1'b0, 1'b0);
      step(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
      lit("pos_overflow", 32'h80000000, 1'b0, 1'b1);
      step(1'b1, 32'h80000000, 32'h80000000, 1'b0);
      lit("neg_overflow", 32'h00000000, 1'b1, 1'b1);
      step(1'b1, 32'h12345678, 32'h0FEDCBA9, 1'b1);
      lit("mixed", 32'h22222222, 1'b0, 1'b0);
      step(1'b0, 32'hFFFF0000, 32'h0001FFFF, 1'b1);
      lit("mid_reset", 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h00000005, 32'h00000003, 1'b1);
      lit("resume", 32'h00000009, 1'b0, 1'b0);
      step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      lit("neg_one_twice", 32'hFFFFFFFE, 1'b1, 1'b0);
      for (int i = 0; i < 10000; i++)
         step(($urandom_range(0, 63) != 0), $urandom, $urandom, 1'(($urandom & 1)));
      @(negedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
